clkctrl_sync_mux: RTL and testbench



---
 rtl/clkctrl_sync_mux.sv | 124 ++++++++++++
 tb/tb_clkctrl_sync_mux.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/clkctrl_sync_mux.sv
// clkctrl_sync_mux: single-clock CPU clock switch. clkout is a registered
// signal in the hsclk_in domain, either a programmable divide of hsclk_in or
// a delayed copy of lsclk_in. Every source switch happens while clkout is
// high, so a high phase may be stretched but is never split.
// Optional build macro: CLKCTRL_SEL_SYNC_EN adds a 2-flop synchroniser on
// hsclk_sel, which delays every switch decision by 2 cycles.
module clkctrl_sync_mux #(
  parameter int DIV_W  = 2,
  parameter int LS_DEL = 3
) (
  input  logic             hsclk_in,
  input  logic             rst,
  input  logic             lsclk_in,
  input  logic             hsclk_sel,
  input  logic [DIV_W-1:0] cpuclk_div_sel,
  output logic             clkout,
  output logic             hsclk_selected,
  output logic             lsclk_selected,
  output logic [DIV_W-1:0] div_active
);

  typedef enum logic [1:0] {ST_LS, ST_HS, ST_HS2LS} state_t;

  state_t              state_q, state_d;
  logic [LS_DEL-1:0]   del_q;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                clk_d;
  logic                sel_s;
  logic                ls_now, ls_next;

`ifdef CLKCTRL_SEL_SYNC_EN
  logic [1:0] sel_sync_q;

  // Two-flop synchroniser for the source request.
  always_ff @(posedge hsclk_in) begin
    if (rst) sel_sync_q <= '0;
    else     sel_sync_q <= {sel_sync_q[0], hsclk_sel};
  end

  assign sel_s = sel_sync_q[1];
`else
  assign sel_s = hsclk_sel;
`endif

  // lsclk_in enters at the top of the pipe; ls_next is what clkout becomes
  // next cycle in LS, ls_now lets us see an LS edge one cycle ahead.
  always_ff @(posedge hsclk_in) begin
    if (rst) del_q <= '0;
    else     del_q <= {lsclk_in, del_q[LS_DEL-1:1]};
  end

  assign ls_now  = del_q[0];
  assign ls_next = del_q[1];

  assign div_active = div_q;

  // Next-state, counter and clock decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    clk_d   = clkout;
    case (state_q)
      ST_LS: begin
        clk_d = ls_next;
        // Leave LS only where an LS fall is pending: hold high instead.
        if (sel_s && clkout && !ls_next) begin
          state_d = ST_HS;
          clk_d   = 1'b1;
          cnt_d   = '0;
          div_d   = cpuclk_div_sel;
        end
      end
      ST_HS: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (clkout && !sel_s) begin
            // Fall point with LS requested: keep high until LS rises.
            state_d = ST_HS2LS;
          end else begin
            clk_d = ~clkout;
            // Divider only reloads at the start of a high phase.
            if (!clkout) div_d = cpuclk_div_sel;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HS2LS: begin
        clk_d = 1'b1;
        // Abort back to HS wins over a pending LS rise.
        if (sel_s) begin
          state_d = ST_HS;
          cnt_d   = '0;
          div_d   = cpuclk_div_sel;
        end else if (!ls_now && ls_next) begin
          state_d = ST_LS;
        end
      end
      default: state_d = ST_LS;
    endcase
  end

  // State, divider and registered outputs.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      state_q        <= ST_LS;
      cnt_q          <= '0;
      div_q          <= '0;
      clkout         <= 1'b0;
      hsclk_selected <= 1'b0;
      lsclk_selected <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      clkout         <= clk_d;
      hsclk_selected <= (state_d == ST_HS);
      lsclk_selected <= (state_d == ST_LS);
    end
  end

endmodule

// File: tb/tb_clkctrl_sync_mux.sv
// Bench for clkctrl_sync_mux: expected clkout values are queued as stimulus
// is driven and popped one per cycle; status outputs are checked at fixed
// points of each directed step.
module tb_clkctrl_sync_mux;
  localparam int DIV_W  = 2;
  localparam int LS_DEL = 3;
`ifdef CLKCTRL_SEL_SYNC_EN
  localparam int SEL_LAT = 2;
`else
  localparam int SEL_LAT = 0;
`endif

  typedef enum {M_NONE, M_LS, M_HOLD} mode_t;

  logic             hsclk_in = 1'b0;
  logic             rst;
  logic             lsclk_in;
  logic             hsclk_sel;
  logic [DIV_W-1:0] cpuclk_div_sel;
  logic             clkout;
  logic             hsclk_selected;
  logic             lsclk_selected;
  logic [DIV_W-1:0] div_active;

  int    checks = 0;
  int    errors = 0;
  int    tk     = 0;
  int    ls_ph  = 15;
  int    e      = 0;
  logic  exp_q[$];
  mode_t mode   = M_NONE;

  clkctrl_sync_mux #(.DIV_W(DIV_W), .LS_DEL(LS_DEL)) dut (
    .hsclk_in       (hsclk_in),
    .rst            (rst),
    .lsclk_in       (lsclk_in),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .clkout         (clkout),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .div_active     (div_active)
  );

  always #5 hsclk_in = ~hsclk_in;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s @%0d got %0h want %0h", tag, tk, got, want);
    end
  endtask

  // One cycle: compare clkout, advance the 16-cycle LS wave, queue expectation.
  task automatic tick();
    logic prev;
    logic want;
    @(posedge hsclk_in); #1;
    tk++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      chk("clkout", 8'(clkout), 8'(want));
    end
    prev     = lsclk_in;
    ls_ph    = (ls_ph + 1) % 16;
    lsclk_in = (ls_ph < 8);
    case (mode)
      M_LS:   exp_q.push_back(lsclk_in);
      M_HOLD: begin
        if (lsclk_in && !prev) mode = M_LS;
        exp_q.push_back(1'b1);
      end
      default: ;
    endcase
  endtask

  task automatic run_to(input int t);
    while (tk < t) tick();
  endtask

  task automatic push_bits(input logic [63:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic check_reset();
    chk("rst_clkout", 8'(clkout), 8'd0);
    chk("rst_ls_sel", 8'(lsclk_selected), 8'd1);
    chk("rst_hs_sel", 8'(hsclk_selected), 8'd0);
    chk("rst_div", 8'(div_active), 8'd0);
  endtask

  // Pipe is cleared by reset, so clkout stays 0 until the first sampled LS value.
  task automatic release_rst();
    rst = 1'b0;
    repeat (LS_DEL - 1) exp_q.push_back(1'b0);
    exp_q.push_back(lsclk_in);
    mode = M_LS;
  endtask

  task automatic chk_sel(input string tag, input logic hs, input logic ls);
    chk({tag, "_hs"}, 8'(hsclk_selected), 8'(hs));
    chk({tag, "_ls"}, 8'(lsclk_selected), 8'(ls));
  endtask

  // Request HS mid LS low; the switch lands 3 cycles after the next LS fall is
  // driven, and e marks the first held-high HS cycle.
  task automatic goto_hs(input logic [DIV_W-1:0] d);
    cpuclk_div_sel = d;
    while (ls_ph != 12) tick();
    hsclk_sel = 1'b1;
    while (ls_ph != 7) tick();
    mode = M_NONE;
    tick();
    e = tk + 3;
  endtask

  initial begin
    rst            = 1'b1;
    hsclk_sel      = 1'b0;
    cpuclk_div_sel = 2'd1;
    lsclk_in       = 1'b0;

    // Reset values, then plain LS following.
    repeat (4) tick();
    check_reset();
    release_rst();
    repeat (40) tick();
    chk_sel("ls_follow", 1'b0, 1'b1);

    // LS->HS with div 1, divider change 1->3 mid high, then div 0 and HS->LS.
    goto_hs(2'd1);
    push_bits(64'(23'b11001100110011110000101), 23);
    run_to(e + 8);
    cpuclk_div_sel = 2'd3;
    run_to(e + 11);
    chk("div_old", 8'(div_active), 8'd1);
    run_to(e + 12);
    chk("div_new", 8'(div_active), 8'd3);
    chk_sel("in_hs", 1'b1, 1'b0);
    cpuclk_div_sel = 2'd0;
    run_to(e + 19);
    mode = M_HOLD;
    run_to(e + 21 - SEL_LAT);
    hsclk_sel = 1'b0;
    run_to(e + 23);
    chk_sel("hs2ls", 1'b0, 1'b0);
    chk("div_zero", 8'(div_active), 8'd0);
    run_to(e + 24);
    chk_sel("back_ls", 1'b0, 1'b1);
    run_to(e + 40);

    // Abort: back to HS in the same cycle an LS rise is pending.
    goto_hs(2'd1);
    push_bits(64'(37'b1100110011111111111111111100110011111), 37);
    run_to(e + 8 - SEL_LAT);
    hsclk_sel = 1'b0;
    run_to(e + 11);
    chk_sel("abort_wait", 1'b0, 1'b0);
    run_to(e + 23 - SEL_LAT);
    hsclk_sel = 1'b1;
    run_to(e + 24);
    chk_sel("abort_hs", 1'b1, 1'b0);

    // Reset while parked in HS2LS.
    run_to(e + 30 - SEL_LAT);
    hsclk_sel = 1'b0;
    run_to(e + 35);
    chk_sel("hs2ls_2", 1'b0, 1'b0);
    run_to(e + 36);
    rst = 1'b1;
    run_to(e + 37);
    check_reset();
    release_rst();
    repeat (24) tick();
    chk_sel("after_rst", 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
